dna_decode_stream: RTL

Converts one packed 2-bit-per-base DNA sequence back into ASCII characters, the inverse of the sequence encoder. It accepts a whole sequence through a valid/ready load handshake and streams it out one character per beat through a valid/ready output handshake. While streaming it counts each base type and reports the counts at end of sequence. It sits downstream of the comparison/alignment logic and feeds text-oriented sinks such as the print/log path and the testbench scoreboard.

---
 rtl/dna_pkg.sv | 37 +++
 rtl/dna_decode_stream.sv | 117 +++++++++++
 2 files changed

// File: rtl/dna_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dna_pkg
//  Purpose : Shared DNA base code map. The 2-bit base codes and their ASCII
//            characters are defined here once, so the encoder and the
//            decoder cannot disagree about the mapping.
//  Contents: base_t, BASE_A/T/G/C, ASCII_A/T/G/C, base_to_ascii()
//  Revision: 1.0  initial release
// ============================================================================
package dna_pkg;

    typedef logic [1:0] base_t;

    localparam base_t BASE_A = 2'b00;
    localparam base_t BASE_T = 2'b01;
    localparam base_t BASE_G = 2'b10;
    localparam base_t BASE_C = 2'b11;

    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_T = 8'h54;
    localparam logic [7:0] ASCII_G = 8'h47;
    localparam logic [7:0] ASCII_C = 8'h43;

    // Every 2-bit code is a legal base, so the map is total.
    function automatic logic [7:0] base_to_ascii(input base_t b);
        logic [7:0] ch;
        case (b)
            BASE_A:  ch = ASCII_A;
            BASE_T:  ch = ASCII_T;
            BASE_G:  ch = ASCII_G;
            default: ch = ASCII_C;
        endcase
        return ch;
    endfunction

endpackage : dna_pkg
`default_nettype wire

// File: rtl/dna_decode_stream.sv
`default_nettype none
// ============================================================================
//  Module  : dna_decode_stream
//  Purpose : Loads one packed 2-bit-per-base sequence and streams it out as
//            ASCII characters, one per valid/ready beat, counting each base
//            type and publishing the totals when the sequence completes.
//  Ports   : clk, reset                    clock, synchronous active-high reset
//            seq, seq_valid, seq_ready     sequence load handshake
//            char_data, char_valid,
//            char_ready, char_last         character output stream
//            done                          pulse after the last character beat
//            count_a/t/g/c                 per-base totals of last sequence
//  Revision: 1.0  initial release
// ============================================================================
module dna_decode_stream #(
    parameter  int LEN = 7,
    localparam int CW  = $clog2(LEN + 2)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [0:LEN][0:1]    seq,
    input  logic                 seq_valid,
    output logic                 seq_ready,
    output logic [7:0]           char_data,
    output logic                 char_valid,
    input  logic                 char_ready,
    output logic                 char_last,
    output logic                 done,
    output logic [CW-1:0]        count_a,
    output logic [CW-1:0]        count_t,
    output logic [CW-1:0]        count_g,
    output logic [CW-1:0]        count_c
);

    import dna_pkg::*;

    localparam int            IW         = (LEN > 0) ? $clog2(LEN + 1) : 1;
    localparam logic [IW-1:0] c_last_idx = IW'(LEN);

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_stream = 1'b1;

    logic [0:0]          r_state;
    logic [0:LEN][0:1]   r_buf;
    logic [IW-1:0]       r_idx;
    logic                r_done;
    // Working counters accumulate during the stream; r_count only changes
    // at completion, so the outputs stay stable between sequences.
    logic [CW-1:0]       r_work  [0:3];
    logic [CW-1:0]       r_count [0:3];

    logic [CW-1:0]       w_work_next [0:3];
    base_t               w_base;
    logic                w_beat;
    logic                w_last;

    assign w_base = r_buf[r_idx];
    assign w_beat = (r_state == c_st_stream) && char_ready;
    assign w_last = (r_idx == c_last_idx);

    // Next working counts including the current beat; also the value
    // published on the final beat so that beat is not lost.
    always_comb begin
        w_work_next = r_work;
        if (w_beat) begin
            w_work_next[w_base] = r_work[w_base] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_buf   <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_work  <= '{default: '0};
            r_count <= '{default: '0};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (seq_valid) begin
                        r_buf   <= seq;
                        r_idx   <= '0;
                        r_work  <= '{default: '0};
                        r_state <= c_st_stream;
                    end
                end
                c_st_stream: begin
                    if (char_ready) begin
                        r_work <= w_work_next;
                        if (w_last) begin
                            r_state <= c_st_idle;
                            r_count <= w_work_next;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign seq_ready  = (r_state == c_st_idle) && !reset;
    assign char_valid = (r_state == c_st_stream);
    assign char_data  = char_valid ? base_to_ascii(w_base) : 8'h00;
    assign char_last  = char_valid && w_last;
    assign done       = r_done;
    assign count_a    = r_count[BASE_A];
    assign count_t    = r_count[BASE_T];
    assign count_g    = r_count[BASE_G];
    assign count_c    = r_count[BASE_C];

endmodule : dna_decode_stream
`default_nettype wire
